// File: rtl/satatrn_rxfifo_pkg.sv
// rtl/satatrn_rxfifo_pkg.sv - shared widths for the receive packet FIFO
package satatrn_rxfifo_pkg;
   localparam int DATA_W  = 32;
   localparam int ENTRY_W = DATA_W + 1;   // stored entry is {last, data}
endpackage

// File: rtl/satatrn_rxfifo_if.sv
// rtl/satatrn_rxfifo_if.sv - reader-side word stream of the receive packet FIFO
interface satatrn_rxfifo_if;
   import satatrn_rxfifo_pkg::*;

   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;

   modport master (output m_valid, output m_data, output m_last, input m_ready);
   modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/satatrn_sdpram.sv
// rtl/satatrn_sdpram.sv - simple dual-port RAM with registered read, storage not reset
module satatrn_sdpram #(
   parameter int AW = 9,
   parameter int DW = 33
) (
   input  logic          i_clk,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [DW-1:0] i_wr_data,
   input  logic          i_rd_en,
   input  logic [AW-1:0] i_rd_addr,
   output logic [DW-1:0] o_rd_data
);
   logic [DW-1:0] r_mem [0:(1<<AW)-1];
   logic [DW-1:0] r_rd_data;

   // write port
   always_ff @(posedge i_clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   // read port; data holds while i_rd_en is low so it can act as a pipeline stage
   always_ff @(posedge i_clk) begin
      if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;
endmodule

// File: rtl/satatrn_rxfifo.sv
// rtl/satatrn_rxfifo.sv - receive packet FIFO with commit/rollback and HOLD flags
module satatrn_rxfifo
   import satatrn_rxfifo_pkg::*;
#(
   parameter int LGFIFO     = 9,
   parameter int HOLD_SLACK = 16
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_last,
   input  logic              i_abort,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_drop,
   output logic              o_overflow,
   satatrn_rxfifo_if.master  m_if
);
   localparam int             PW    = LGFIFO + 1;
   localparam logic [PW-1:0]  DEPTH = {1'b1, {LGFIFO{1'b0}}};

   typedef enum logic [1:0] {W_IDLE, W_PKT, W_DISCARD} wstate_t;

   wstate_t            r_state, w_state_n;
   logic [PW-1:0]      r_wr_addr, r_wr_commit, r_rd_addr;
   logic [PW-1:0]      w_wr_addr_n, w_wr_commit_n, w_fill, w_free;
   logic               w_wr_en, w_drop_n, w_ovf_set, w_true_full;
   logic               r_drop, r_overflow, r_full, r_empty;
   logic               r_ram_vld, r_m_valid, r_m_last;
   logic [DATA_W-1:0]  r_m_data;
   logic               w_rd_en, w_out_load;
   logic [ENTRY_W-1:0] w_ram_q;

   assign w_fill      = r_wr_addr - r_rd_addr;
   assign w_free      = DEPTH - w_fill;
   assign w_true_full = (w_fill == DEPTH);

   // write FSM next state: abort beats overflow beats last beats plain data
   always_comb begin
      w_state_n     = r_state;
      w_wr_addr_n   = r_wr_addr;
      w_wr_commit_n = r_wr_commit;
      w_wr_en       = 1'b0;
      w_drop_n      = 1'b0;
      w_ovf_set     = 1'b0;
      if (i_abort) begin
         w_wr_addr_n = r_wr_commit;
         w_drop_n    = (r_wr_addr != r_wr_commit) || (r_state != W_IDLE);
         w_state_n   = W_IDLE;
      end else if (i_valid) begin
         if (r_state == W_DISCARD) begin
            if (i_last) begin
               w_wr_addr_n = r_wr_commit;
               w_drop_n    = 1'b1;
               w_state_n   = W_IDLE;
            end
         end else if (w_true_full) begin
            // a frame that ends on the rejected word is dropped at once
            w_ovf_set = 1'b1;
            if (i_last) begin
               w_wr_addr_n = r_wr_commit;
               w_drop_n    = 1'b1;
               w_state_n   = W_IDLE;
            end else begin
               w_state_n = W_DISCARD;
            end
         end else begin
            w_wr_en     = 1'b1;
            w_wr_addr_n = r_wr_addr + 1'b1;
            if (i_last) begin
               w_wr_commit_n = r_wr_addr + 1'b1;
               w_state_n     = W_IDLE;
            end else begin
               w_state_n = W_PKT;
            end
         end
      end
   end

   // write-side state, pointers, drop pulse and sticky overflow
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= W_IDLE;
         r_wr_addr   <= '0;
         r_wr_commit <= '0;
         r_drop      <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_wr_addr   <= w_wr_addr_n;
         r_wr_commit <= w_wr_commit_n;
         r_drop      <= w_drop_n;
         if (w_ovf_set) r_overflow <= 1'b1;
      end
   end

   // read pipeline: RAM read register, then the held output register
   assign w_out_load = r_ram_vld && (!r_m_valid || m_if.m_ready);
   assign w_rd_en    = (r_rd_addr != r_wr_commit) && (!r_ram_vld || w_out_load);

   satatrn_sdpram #(.AW(LGFIFO), .DW(ENTRY_W)) u_ram (
      .i_clk     (i_clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_wr_addr[LGFIFO-1:0]),
      .i_wr_data ({i_last, i_data}),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (r_rd_addr[LGFIFO-1:0]),
      .o_rd_data (w_ram_q)
   );

   // read pointer, RAM-stage valid and output register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rd_addr <= '0;
         r_ram_vld <= 1'b0;
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_m_last  <= 1'b0;
      end else begin
         if (w_rd_en) r_rd_addr <= r_rd_addr + 1'b1;
         if (w_rd_en)         r_ram_vld <= 1'b1;
         else if (w_out_load) r_ram_vld <= 1'b0;
         if (w_out_load) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_ram_q[DATA_W-1:0];
            r_m_last  <= w_ram_q[DATA_W];
         end else if (m_if.m_ready) begin
            r_m_valid <= 1'b0;
         end
      end
   end

   // link throttle flags, one cycle behind the pointers
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         r_full  <= (w_free <= PW'(HOLD_SLACK));
         r_empty <= (r_rd_addr == r_wr_commit) && (r_wr_addr == r_wr_commit) &&
                    !r_ram_vld && !r_m_valid && (r_state == W_IDLE);
      end
   end

   assign o_full       = r_full;
   assign o_empty      = r_empty;
   assign o_drop       = r_drop;
   assign o_overflow   = r_overflow;
   assign m_if.m_valid = r_m_valid;
   assign m_if.m_data  = r_m_data;
   assign m_if.m_last  = r_m_last;
endmodule

// File: tb/tb_satatrn_rxfifo.sv
// tb/tb_satatrn_rxfifo.sv - self-checking bench for the receive packet FIFO
module tb_satatrn_rxfifo;
   logic        clk, rst_n;
   logic        v0, l0, a0, v1, l1, a1;
   logic [31:0] d0, d1;
   logic        full0, empty0, drop0, ovf0;
   logic        full1, empty1, drop1, ovf1;
   int          n_checks, n_fail;

   satatrn_rxfifo_if if0();
   satatrn_rxfifo_if if1();

   satatrn_rxfifo dut0 (
      .i_clk(clk), .i_reset_n(rst_n), .i_valid(v0), .i_data(d0), .i_last(l0), .i_abort(a0),
      .o_full(full0), .o_empty(empty0), .o_drop(drop0), .o_overflow(ovf0), .m_if(if0));

   satatrn_rxfifo #(.LGFIFO(4), .HOLD_SLACK(4)) dut1 (
      .i_clk(clk), .i_reset_n(rst_n), .i_valid(v1), .i_data(d1), .i_last(l1), .i_abort(a1),
      .o_full(full1), .o_empty(empty1), .o_drop(drop1), .o_overflow(ovf1), .m_if(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // drive one cycle to the selected instance, then step to just after the edge
   task automatic cyc(input bit sel, input bit v, input logic [31:0] d, input bit l, input bit a);
      v0 = 0; d0 = '0; l0 = 0; a0 = 0; v1 = 0; d1 = '0; l1 = 0; a1 = 0;
      if (!sel) begin v0 = v; d0 = d; l0 = l; a0 = a; end
      else      begin v1 = v; d1 = d; l1 = l; a1 = a; end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
   endtask

   // frame-level model of instance 0: pending frame, committed words, drop/overflow
   logic [32:0] pend[$];
   logic [32:0] sb[$];
   int          mst;            // 0 between frames, 1 in frame, 2 discarding
   logic        exp_drop, exp_ovf, hold_v;
   logic [32:0] hold_word, got;

   always @(negedge clk) begin
      if (!rst_n) begin
         pend.delete(); sb.delete(); mst = 0;
         exp_drop = 0; exp_ovf = 0; hold_v = 0;
      end else begin
         check("cmp_drop", 64'(drop0), 64'(exp_drop));
         check("cmp_overflow", 64'(ovf0), 64'(exp_ovf));
         if (hold_v) begin
            check("cmp_hold_valid", 64'(if0.m_valid), 64'd1);
            check("cmp_hold_word", 64'({if0.m_last, if0.m_data}), 64'(hold_word));
         end
         hold_v    = if0.m_valid && !if0.m_ready;
         hold_word = {if0.m_last, if0.m_data};
         if (if0.m_valid && if0.m_ready) begin
            got = {if0.m_last, if0.m_data};
            if (sb.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL cmp_unexpected_word actual=%0h expected=none t=%0t", got, $time);
            end else begin
               check("cmp_read_word", 64'(got), 64'(sb.pop_front()));
            end
         end
         exp_drop = 0;
         if (a0) begin
            if (pend.size() > 0 || mst != 0) exp_drop = 1;
            pend.delete(); mst = 0;
         end else if (v0) begin
            if (mst == 2) begin
               if (l0) begin exp_drop = 1; pend.delete(); mst = 0; end
            end else if (pend.size() + sb.size() >= 512) begin
               exp_ovf = 1;
               if (l0) begin exp_drop = 1; pend.delete(); mst = 0; end
               else mst = 2;
            end else begin
               pend.push_back({l0, d0});
               if (l0) begin
                  foreach (pend[i]) sb.push_back(pend[i]);
                  pend.delete(); mst = 0;
               end else mst = 1;
            end
         end
      end
   end

   initial begin
      n_checks = 0; n_fail = 0;
      rst_n = 0; if0.m_ready = 0; if1.m_ready = 0;
      v0 = 0; d0 = '0; l0 = 0; a0 = 0; v1 = 0; d1 = '0; l1 = 0; a1 = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_valid", 64'(if0.m_valid), 64'd0);
      check("rst_m_data", 64'(if0.m_data), 64'd0);
      check("rst_m_last", 64'(if0.m_last), 64'd0);
      check("rst_drop", 64'(drop0), 64'd0);
      check("rst_overflow", 64'(ovf0), 64'd0);
      check("rst_full", 64'(full0), 64'd0);
      check("rst_empty", 64'(empty0), 64'd1);
      rst_n = 1;
      idle(2);

      // single 4-word frame, reader always ready
      if0.m_ready = 1;
      for (int k = 1; k <= 4; k++) cyc(0, 1, 32'(k), k == 4, 0);
      idle(1);
      check("t1_valid_n1", 64'(if0.m_valid), 64'd0);
      for (int k = 1; k <= 4; k++) begin
         idle(1);
         check("t1_valid", 64'(if0.m_valid), 64'd1);
         check("t1_data", 64'(if0.m_data), 64'(k));
         check("t1_last", 64'(if0.m_last), 64'(k == 4));
      end
      idle(1);
      check("t1_valid_end", 64'(if0.m_valid), 64'd0);
      idle(3);
      check("t1_empty", 64'(empty0), 64'd1);

      // three words then a bare abort, followed by a good 2-word frame
      cyc(0, 1, 32'h21, 0, 0); cyc(0, 1, 32'h22, 0, 0); cyc(0, 1, 32'h23, 0, 0);
      cyc(0, 0, 0, 0, 1);
      check("t2_drop", 64'(drop0), 64'd1);
      check("t2_rollback", 64'(dut0.r_wr_addr), 64'd4);
      idle(1);
      check("t2_drop_pulse", 64'(drop0), 64'd0);
      check("t2_no_valid", 64'(if0.m_valid), 64'd0);
      cyc(0, 1, 32'h31, 0, 0); cyc(0, 1, 32'h32, 1, 0);
      idle(6);
      check("t2_empty", 64'(empty0), 64'd1);

      // committed frame A held while frame B is aborted
      if0.m_ready = 0;
      cyc(0, 1, 32'hA0, 0, 0); cyc(0, 1, 32'hA1, 1, 0);
      cyc(0, 1, 32'hB0, 0, 0); cyc(0, 1, 32'hB1, 0, 0); cyc(0, 1, 32'hB2, 0, 0);
      cyc(0, 0, 0, 0, 1);
      check("t3_drop", 64'(drop0), 64'd1);
      idle(3);
      check("t3_head_valid", 64'(if0.m_valid), 64'd1);
      check("t3_head_data", 64'(if0.m_data), 64'hA0);
      if0.m_ready = 1;
      idle(6);
      check("t3_drained", 64'(if0.m_valid), 64'd0);
      check("t3_empty", 64'(empty0), 64'd1);

      // last and abort together on word 3
      cyc(0, 1, 32'h51, 0, 0); cyc(0, 1, 32'h52, 0, 0);
      cyc(0, 1, 32'h53, 1, 1);
      check("t5_drop", 64'(drop0), 64'd1);
      idle(4);
      check("t5_no_valid", 64'(if0.m_valid), 64'd0);
      check("t5_empty", 64'(empty0), 64'd1);

      // small instance: 20-word frame into 16 words with reader stalled
      for (int k = 1; k <= 20; k++) begin
         cyc(1, 1, 32'(k), k == 20, 0);
         check($sformatf("t4_full_w%0d", k), 64'(full1), 64'(k >= 13));
         check($sformatf("t4_ovf_w%0d", k), 64'(ovf1), 64'(k >= 17));
         check($sformatf("t4_drop_w%0d", k), 64'(drop1), 64'(k == 20));
         check($sformatf("t4_valid_w%0d", k), 64'(if1.m_valid), 64'd0);
      end
      check("t4_rollback", 64'(dut1.r_wr_addr), 64'd0);
      idle(1);
      check("t4_full_clear", 64'(full1), 64'd0);
      check("t4_drop_pulse", 64'(drop1), 64'd0);
      check("t4_ovf_sticky", 64'(ovf1), 64'd1);
      idle(1);
      check("t4_empty", 64'(empty1), 64'd1);
      check("t4_no_valid", 64'(if1.m_valid), 64'd0);

      // reset in the middle of reading a 5-word committed frame
      if0.m_ready = 0;
      for (int k = 0; k < 5; k++) cyc(0, 1, 32'h61 + 32'(k), k == 4, 0);
      idle(4);
      check("t6_valid", 64'(if0.m_valid), 64'd1);
      check("t6_data", 64'(if0.m_data), 64'h61);
      if0.m_ready = 1;
      idle(2);
      #2 rst_n = 0;
      #1;
      check("t6_rst_valid", 64'(if0.m_valid), 64'd0);
      check("t6_rst_data", 64'(if0.m_data), 64'd0);
      check("t6_rst_last", 64'(if0.m_last), 64'd0);
      check("t6_rst_drop", 64'(drop0), 64'd0);
      check("t6_rst_ovf", 64'(ovf0), 64'd0);
      check("t6_rst_full", 64'(full0), 64'd0);
      check("t6_rst_empty", 64'(empty0), 64'd1);
      check("t6_rst_ovf1", 64'(ovf1), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      idle(3);
      check("t6_empty_after", 64'(empty0), 64'd1);
      check("t6_valid_after", 64'(if0.m_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
